// File: rtl/rr_arbiter_pkg.sv
// Shared definitions for the round-robin arbiter: FSM state encoding,
// default sizing and a constant-evaluable clog2 helper.
package rr_arbiter_pkg;

  localparam int DEF_NUM_REQ  = 8;
  localparam int DEF_MAX_HOLD = 16;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_t;

  // Number of bits needed to index n items (n >= 2).
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) begin
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter_prio_pick.sv
// Combinational round-robin picker. Among the requests not excluded, it
// returns the lowest index at or above ptr; if none exists it falls back to
// the lowest requesting index overall. Both searches use the same LSB-first
// isolate-lowest-bit finder.
module rr_arbiter_prio_pick #(
  parameter int NUM_REQ = 8,
  parameter int ID_W    = 3
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  input  logic [NUM_REQ-1:0] excl_mask,
  output logic [NUM_REQ-1:0] onehot,
  output logic [ID_W-1:0]    idx,
  output logic               any
);

  logic [NUM_REQ-1:0] cand;
  logic [NUM_REQ-1:0] ptr_mask;
  logic [NUM_REQ-1:0] masked;
  logic [NUM_REQ-1:0] search;

  assign cand = req & ~excl_mask;

  // Thermometer mask selecting positions at or above the pointer.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ptr_mask
      assign ptr_mask[gi] = (ID_W'(gi) >= ptr);
    end
  endgenerate

  assign masked = cand & ptr_mask;

  // Masked finder wins when it has any candidate, otherwise wrap around.
  assign search = (|masked) ? masked : cand;

  // Isolate the lowest set bit (two's complement trick).
  assign onehot = search & (~search + NUM_REQ'(1));
  assign any    = |cand;

  // Encode the one-hot winner into an index.
  always_comb begin
    idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (onehot[i]) begin
        idx = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin, grant-holding arbiter. A registered one-hot grant stays with
// its owner until the owner drops req or the hold limit expires; the
// priority pointer then moves past the winner so nobody starves.
module rr_arbiter
  import rr_arbiter_pkg::*;
#(
  parameter int NUM_REQ  = DEF_NUM_REQ,
  parameter int ID_W     = clog2(NUM_REQ),
  parameter int MAX_HOLD = DEF_MAX_HOLD,
  parameter int CNT_W    = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic               gnt_valid,
  output logic [ID_W-1:0]    gnt_id,
  output logic               revoked
);

  localparam bit               HOLD_LIMITED = (MAX_HOLD != 0);
  localparam logic [CNT_W-1:0] HOLD_LAST    = HOLD_LIMITED ? CNT_W'(MAX_HOLD - 1) : '0;
  localparam logic [CNT_W-1:0] HOLD_SAT     = CNT_W'(MAX_HOLD);
  localparam logic [ID_W-1:0]  LAST_ID      = ID_W'(NUM_REQ - 1);

  arb_state_t         state_reg, state_next;
  logic [ID_W-1:0]    ptr_reg, ptr_next;
  logic [CNT_W-1:0]   hold_cnt_reg, hold_cnt_next;
  logic [NUM_REQ-1:0] gnt_reg, gnt_next;
  logic               gnt_valid_reg, gnt_valid_next;
  logic [ID_W-1:0]    gnt_id_reg, gnt_id_next;
  logic               revoked_reg, revoked_next;

  logic [NUM_REQ-1:0] excl_mask;
  logic [NUM_REQ-1:0] pick_onehot;
  logic [ID_W-1:0]    pick_idx;
  logic               pick_any;
  logic               owner_req;
  logic               release_hit;
  logic               timeout_hit;
  logic               take_grant;

  // While granted, the current owner is excluded from the hand-off search.
  assign excl_mask = (state_reg == ST_GRANT) ? gnt_reg : '0;
  assign owner_req = |(req & gnt_reg);

  rr_arbiter_prio_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .req       (req),
    .ptr       (ptr_reg),
    .excl_mask (excl_mask),
    .onehot    (pick_onehot),
    .idx       (pick_idx),
    .any       (pick_any)
  );

  // Next-state and next-output decisions for the IDLE/GRANT controller.
  always_comb begin
    state_next     = state_reg;
    ptr_next       = ptr_reg;
    hold_cnt_next  = hold_cnt_reg;
    gnt_next       = gnt_reg;
    gnt_valid_next = gnt_valid_reg;
    gnt_id_next    = gnt_id_reg;
    revoked_next   = 1'b0;
    take_grant     = 1'b0;
    release_hit    = 1'b0;
    timeout_hit    = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (pick_any) begin
          take_grant = 1'b1;
        end
      end
      ST_GRANT: begin
        release_hit = ~owner_req;
        // A release in the same cycle as the limit counts as a release.
        timeout_hit = HOLD_LIMITED && (hold_cnt_reg == HOLD_LAST) && owner_req;
        if (release_hit || timeout_hit) begin
          revoked_next = timeout_hit;
          if (pick_any) begin
            take_grant = 1'b1;
          end else begin
            state_next     = ST_IDLE;
            gnt_next       = '0;
            gnt_valid_next = 1'b0;
            gnt_id_next    = '0;
            hold_cnt_next  = '0;
          end
        end else if (hold_cnt_reg != HOLD_SAT) begin
          hold_cnt_next = hold_cnt_reg + CNT_W'(1);
        end
      end
      default: begin
        state_next     = ST_IDLE;
        gnt_next       = '0;
        gnt_valid_next = 1'b0;
        gnt_id_next    = '0;
        hold_cnt_next  = '0;
      end
    endcase

    // Any new grant: load the winner, rotate the pointer past it, restart hold.
    if (take_grant) begin
      state_next     = ST_GRANT;
      gnt_next       = pick_onehot;
      gnt_valid_next = 1'b1;
      gnt_id_next    = pick_idx;
      hold_cnt_next  = '0;
      ptr_next       = (pick_idx == LAST_ID) ? '0 : pick_idx + ID_W'(1);
    end
  end

  // State, pointer, hold counter and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      ptr_reg       <= '0;
      hold_cnt_reg  <= '0;
      gnt_reg       <= '0;
      gnt_valid_reg <= 1'b0;
      gnt_id_reg    <= '0;
      revoked_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      ptr_reg       <= ptr_next;
      hold_cnt_reg  <= hold_cnt_next;
      gnt_reg       <= gnt_next;
      gnt_valid_reg <= gnt_valid_next;
      gnt_id_reg    <= gnt_id_next;
      revoked_reg   <= revoked_next;
    end
  end

  assign gnt       = gnt_reg;
  assign gnt_valid = gnt_valid_reg;
  assign gnt_id    = gnt_id_reg;
  assign revoked   = revoked_reg;

endmodule
